// File: rtl/mac_v3.sv
// -----------------------------------------------------------------------------
// mac_v3 - parametrised multiply-accumulate engine
//
// Accumulates the products of a stream of operand pairs over a vector of up to
// N pairs. A vector ends on its Nth pair or early on in_last; the sum and the
// vector length are then presented for one cycle from registers.
//
// Build option:
//   MAC_V3_SIGNED_EN  defined -> operands and result are two's complement
//                     undefined -> operands and result are unsigned
//
// Parameters:
//   W   operand width (>= 2)
//   N   maximum pairs per vector (>= 2)
//   OW  result width, 2*W + clog2(N) (derived, do not override)
//   LW  length width, clog2(N+1)     (derived, do not override)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand pair present this cycle
//   in_last    in   final pair of the vector (qualified by in_valid)
//   in1_IFM    in   operand A [W]
//   in2_IFM    in   operand B [W]
//   out_valid  out  one-cycle pulse, out/out_len updated
//   out        out  sum of products of the completed vector [OW]
//   out_len    out  number of pairs in the completed vector [LW]
// -----------------------------------------------------------------------------
module mac_v3 #(
   parameter  int W  = 4,
   parameter  int N  = 4,
   localparam int OW = 2*W + $clog2(N),
   localparam int LW = $clog2(N+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic [W-1:0]  in1_IFM,
   input  logic [W-1:0]  in2_IFM,
   output logic          out_valid,
   output logic [OW-1:0] out,
   output logic [LW-1:0] out_len
);

   typedef enum logic {IDLE, ACC} state_t;

   state_t          r_state,     w_state_nxt;
   logic [OW-1:0]   r_acc,       w_acc_nxt;
   logic [LW-1:0]   r_cnt,       w_cnt_nxt;
   logic            r_out_valid, w_out_valid_nxt;
   logic [OW-1:0]   r_out,       w_out_nxt;
   logic [LW-1:0]   r_out_len,   w_out_len_nxt;

   logic [2*W-1:0]  w_a_ext;
   logic [2*W-1:0]  w_b_ext;
   logic [2*W-1:0]  w_prod;
   logic [OW-1:0]   w_prod_ext;
   logic [OW-1:0]   w_sum;
   logic            w_term;

   // Operands are widened to 2W before multiplying; the low 2W bits of the
   // product of two sign-extended values equal the signed product, so one
   // unsigned multiplier serves both arithmetic modes.
`ifdef MAC_V3_SIGNED_EN
   assign w_a_ext    = {{W{in1_IFM[W-1]}}, in1_IFM};
   assign w_b_ext    = {{W{in2_IFM[W-1]}}, in2_IFM};
   assign w_prod     = w_a_ext * w_b_ext;
   assign w_prod_ext = {{(OW-2*W){w_prod[2*W-1]}}, w_prod};
`else
   assign w_a_ext    = {{W{1'b0}}, in1_IFM};
   assign w_b_ext    = {{W{1'b0}}, in2_IFM};
   assign w_prod     = w_a_ext * w_b_ext;
   assign w_prod_ext = {{(OW-2*W){1'b0}}, w_prod};
`endif

   assign w_sum  = r_acc + w_prod_ext;
   assign w_term = in_last || (r_cnt == LW'(N-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_out_len   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out       <= w_out_nxt;
         r_out_len   <= w_out_len_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_out_valid_nxt = 1'b0;
      w_out_nxt       = r_out;
      w_out_len_nxt   = r_out_len;
      if (in_valid) begin
         if (w_term) begin
            w_out_nxt       = w_sum;
            w_out_len_nxt   = r_cnt + LW'(1);
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_state_nxt     = IDLE;
         end else begin
            w_acc_nxt       = w_sum;
            w_cnt_nxt       = r_cnt + LW'(1);
            w_state_nxt     = ACC;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out       = r_out;
   assign out_len   = r_out_len;

endmodule

// File: doc/mac_v3.md
# mac_v3

Parametrised multiply-accumulate engine, successor to the fixed 4-bit / 4-pair MAC. It accepts a stream of operand pairs and accumulates their products over a vector of up to `N` pairs. It terminates the vector either on the `N`th pair or early on an `in_last` flag, then emits a one-cycle registered result with the vector length. It sits between the IFM feeder and the OFM writeback, and its default parameters reproduce the previous generation's 4-bit inputs and 10-bit output.

## Interface
- `W`, default 4: operand width (bits) of `in1_IFM`/`in2_IFM`, W ≥ 2.
- `N`, default 4: maximum pairs per vector, N ≥ 2.
- `OW`, derived = 2*W + $clog2(N): result width (default 10); not to be overridden.
- `LW`, derived = $clog2(N+1): length-count width (default 3).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, **asynchronous and active-high**.
- `in_valid`  in  1  operand pair present this cycle.
- `in_last`  in  1  qualifies by `in_valid`; marks the final pair of the vector.
- `in1_IFM`  in  W  operand A.
- `in2_IFM`  in  W  operand B.
- `out_valid`  out  1  one-cycle pulse: `out`/`out_len` are updated this cycle.
- `out`  out  OW  sum of products of the completed vector.
- `out_len`  out  LW  number of pairs in the completed vector (1..N).

## Operation
- States:
  - IDLE: `cnt` = 0, `acc` = 0.
  - ACC: 1 ≤ `cnt` < N.
- A sample is accepted on each rising edge with `in_valid` = 1. There is no backpressure; the block accepts every valid cycle.
- `prod` = `in1_IFM` × `in2_IFM`, 2W bits. `sum` = `acc` + `prod`, OW bits.
- Accepted sample, non-terminating: `acc` ← `sum`, `cnt` ← `cnt` + 1, and the state moves to or stays in ACC.
- Terminating sample (`in_last` = 1, or `cnt` = N−1): `out` ← `sum`, `out_len` ← `cnt` + 1, `out_valid` ← 1, `acc` ← 0, `cnt` ← 0, and the state moves to IDLE.
- `in_valid` = 0: `acc` and `cnt` hold, so gaps inside a vector are allowed. `in_last` is ignored.
- `in_last` together with `in_valid` in IDLE produces a 1-pair vector, with `out_len` = 1.
- OW guarantees the result never overflows for any N pairs in either arithmetic mode. No saturation logic is required.
- `out` and `out_len` hold their last value until the next `out_valid`. `out_valid` is 0 in every other cycle.

## Timing
- Reset values: `out_valid` = 0, `out` = 0, `out_len` = 0, `acc` = 0, `cnt` = 0, state IDLE. Reset applies immediately on assertion; release is synchronous to `clk` by the system.
- Latency: `out_valid` rises in the cycle after the edge that accepts the terminating sample (1 cycle). Outputs come directly from flops.
- Back-to-back vectors: the first sample of the next vector may be accepted on the same edge that registers the previous result. No bubble is required. Continuous full-rate input with N = 4 gives one `out_valid` every 4 cycles.
- Reset mid-vector discards the partial `acc`/`cnt`, and no `out_valid` is produced for it.
- `rst` asserted in the cycle `out_valid` would rise: the reset wins and the outputs are 0.

## Configuration
- `MAC_V3_SIGNED_EN` defined: operands and `out` are two's complement.
  - `prod` is the signed product, sign-extended to OW bits before accumulation.
- Not defined: operands are unsigned, `prod` is zero-extended, and `out` is unsigned.
- `out_len` is unsigned in both modes.

## Test plan
- Default params, unsigned: 4 consecutive pairs (15,15), no `in_last` -> one `out_valid` the cycle after the 4th, `out` = 900, `out_len` = 4.
- Early termination: (3,2) then (1,5) with `in_last` -> `out` = 11, `out_len` = 2, 1-cycle latency; a following (2,2)×4 -> `out` = 16.
- Gaps and back-to-back: (1,2),idle,(2,3),idle,idle,(1,1),(4,4) then immediately (1,1)×4 -> `out` = 25, `out_len` = 4, then next `out_valid` exactly 4 cycles later with `out` = 4.
- Reset mid-vector: accept (7,7),(7,7), pulse `rst`, then (1,1)×4 -> only one `out_valid`, with `out` = 4. All outputs are 0 during reset.
- Signedness, (4'b1000, 4'b0111)×4:
  - With `MAC_V3_SIGNED_EN`: `out` = −224 (10'h320).
  - Without it: `out` = 224 (10'h0E0).
- Single-pair vector: `in_last` on the first sample (5,3) -> `out` = 15, `out_len` = 1.
